// File: rtl/pc_adder_control.sv
// rtl/pc_adder_control.sv - program counter with branch/jump adder and optional misalign trap
// Optional feature: define PC_MISALIGN_CHECK_EN to hold pc on misaligned redirect targets.
module pc_adder_control #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enpc,
  input  logic            jal,
  input  logic            jalr,
  input  logic            b,
  input  logic            comp,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] imm_j,
  input  logic [XLEN-1:0] imm_b,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] next_pc,
  output logic            redirect,
  output logic            misaligned
);

  localparam logic [XLEN-1:0] FOUR     = XLEN'(4);
  localparam logic [XLEN-1:0] BIT0_CLR = ~XLEN'(1);

  logic            taken;
  logic [XLEN-1:0] offset;
  logic [XLEN-1:0] increment;
  logic [XLEN-1:0] sum;

  // A single adder serves both sequential and pc-relative targets.
  always_comb begin
    taken     = jal | (comp & b);
    offset    = b ? imm_b : imm_j;
    increment = taken ? offset : FOUR;
    sum       = pc + increment;
    next_pc   = jalr ? (rd1 & BIT0_CLR) : sum;
    redirect  = jalr | taken;
    pc_plus4  = pc + FOUR;
  end

`ifdef PC_MISALIGN_CHECK_EN
  logic trap;

  always_comb begin
    trap = enpc & redirect & (next_pc[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      misaligned <= 1'b0;
    end else begin
      misaligned <= trap;
      if (trap) begin
        pc <= pc;
      end else if (enpc) begin
        pc <= next_pc;
      end else begin
        pc <= pc_plus4;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (enpc) begin
      pc <= next_pc;
    end else begin
      pc <= pc_plus4;
    end
  end

  assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_pc_adder_control.sv
// tb/tb_pc_adder_control.sv - self-checking bench for pc_adder_control
module tb_pc_adder_control;

`ifdef PC_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, enpc, jal, jalr, b, comp;
  logic [31:0] rd1, imm_j, imm_b;
  logic [31:0] pc, pc_plus4, next_pc;
  logic        redirect, misaligned;

  int errors = 0;
  int checks = 0;

  pc_adder_control #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .enpc(enpc), .jal(jal), .jalr(jalr), .b(b), .comp(comp),
    .rd1(rd1), .imm_j(imm_j), .imm_b(imm_b), .pc(pc), .pc_plus4(pc_plus4),
    .next_pc(next_pc), .redirect(redirect), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] start_pc;
    logic        enpc, jal, jalr, b, comp;
    logic [31:0] rd1, imm_j, imm_b;
    logic [31:0] exp_next;
    logic        exp_redirect;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_ctl();
    enpc = 0; jal = 0; jalr = 0; b = 0; comp = 0;
    rd1 = 0; imm_j = 0; imm_b = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Jump straight to an aligned address through jalr.
  task automatic set_pc(input logic [31:0] target);
    rst = 0;
    clear_ctl();
    enpc = 1; jalr = 1; rd1 = target;
    tick();
    clear_ctl();
  endtask

  // Reference: the address the architecture says comes next.
  function automatic logic [31:0] ref_target(input logic [31:0] cur, input logic f_jalr,
      input logic f_jal, input logic f_b, input logic f_comp, input logic [31:0] r,
      input logic [31:0] ij, input logic [31:0] ib);
    longint unsigned t;
    if (f_jalr) return {r[31:1], 1'b0};
    if (f_jal || (f_b && f_comp)) begin
      t = longint'(cur) + longint'(f_b ? ib : ij);
      return t[31:0];
    end
    t = longint'(cur) + 4;
    return t[31:0];
  endfunction

  initial begin
    logic [31:0] m_pc;
    logic        m_mis;
    logic [31:0] tgt;
    logic        red;

    vecs[0] = '{32'h10, 1,0,0,1,1, 32'h0, 32'h0, 32'hFFFF_FFF8, 32'h08, 1, 32'h08, 0};
    vecs[1] = '{32'h10, 1,0,0,1,0, 32'h0, 32'h0, 32'hFFFF_FFF8, 32'h14, 0, 32'h14, 0};
    vecs[2] = '{32'h20, 1,1,0,0,0, 32'h0, 32'h100, 32'h0, 32'h120, 1, 32'h120, 0};
    vecs[3] = '{32'h20, 0,1,0,0,0, 32'h0, 32'h100, 32'h0, 32'h120, 1, 32'h24, 0};
    vecs[4] = '{32'h40, 1,1,1,0,0, 32'h1235, 32'h100, 32'h0, 32'h1234, 1, 32'h1234, 0};
    vecs[5] = '{32'hFFFF_FFFC, 1,0,0,0,0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 0};
    vecs[6] = '{32'h0, 1,1,0,0,0, 32'h0, 32'h2, 32'h0, 32'h2, 1, (MIS_EN ? 32'h0 : 32'h2), MIS_EN};
    vecs[7] = '{32'h100, 1,1,0,1,0, 32'h0, 32'h800, 32'h40, 32'h140, 1, 32'h140, 0};
    vecs[8] = '{32'h40, 1,0,1,0,0, 32'h1003, 32'h0, 32'h0, 32'h1002, 1, (MIS_EN ? 32'h40 : 32'h1002), MIS_EN};

    rst = 1;
    clear_ctl();
    tick();
    chk("reset_pc", pc, 32'h0);
    chk("reset_mis", {31'b0, misaligned}, 32'h0);
    rst = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("seq_pc_%0d", i), pc, 32'(4 * i));
    end

    for (int i = 0; i < 9; i++) begin
      set_pc(vecs[i].start_pc);
      enpc = vecs[i].enpc; jal = vecs[i].jal; jalr = vecs[i].jalr;
      b = vecs[i].b; comp = vecs[i].comp;
      rd1 = vecs[i].rd1; imm_j = vecs[i].imm_j; imm_b = vecs[i].imm_b;
      #1;
      chk($sformatf("v%0d_next_pc", i), next_pc, vecs[i].exp_next);
      chk($sformatf("v%0d_redirect", i), {31'b0, redirect}, {31'b0, vecs[i].exp_redirect});
      chk($sformatf("v%0d_pc_plus4", i), pc_plus4, vecs[i].start_pc + 32'd4);
      tick();
      chk($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
      chk($sformatf("v%0d_mis", i), {31'b0, misaligned}, {31'b0, vecs[i].exp_mis});
    end

    // Misalign flag lasts one cycle only.
    set_pc(32'h0);
    enpc = 1; jal = 1; imm_j = 32'h2;
    tick();
    clear_ctl();
    tick();
    chk("mis_clear_pc", pc, (MIS_EN ? 32'h0 : 32'h2) + 32'd4);
    chk("mis_clear_flag", {31'b0, misaligned}, 32'h0);

    // Reset overrides a jump, then the first free edge follows the jump.
    set_pc(32'h80);
    rst = 1; enpc = 1; jal = 1; imm_j = 32'h100;
    tick();
    chk("rst_over_jal", pc, 32'h0);
    rst = 0;
    tick();
    chk("post_rst_jal", pc, 32'h100);

    // Randomized run against the reference.
    clear_ctl();
    rst = 1;
    tick();
    m_pc = 32'h0; m_mis = 0;
    for (int n = 0; n < 300; n++) begin
      rst  = ($urandom_range(0, 29) == 0);
      enpc = $urandom_range(0, 3) != 0;
      jal  = $urandom_range(0, 3) == 0;
      jalr = $urandom_range(0, 5) == 0;
      b    = $urandom_range(0, 2) == 0;
      comp = $urandom_range(0, 1);
      rd1  = $urandom;
      imm_j = ($urandom_range(0, 7) == 0) ? $urandom : {{20{1'b0}}, 10'($urandom), 2'b00} - 32'h800;
      imm_b = ($urandom_range(0, 7) == 0) ? $urandom : {{20{1'b0}}, 10'($urandom), 2'b00} - 32'h800;
      #1;
      tgt = ref_target(m_pc, jalr, jal, b, comp, rd1, imm_j, imm_b);
      red = jalr || jal || (b && comp);
      chk("rnd_next_pc", next_pc, tgt);
      chk("rnd_redirect", {31'b0, redirect}, {31'b0, red});
      tick();
      if (rst) begin
        m_pc = 32'h0; m_mis = 0;
      end else if (!enpc) begin
        m_pc = m_pc + 32'd4; m_mis = 0;
      end else if (MIS_EN && red && (tgt % 4 != 0)) begin
        m_mis = 1;
      end else begin
        m_pc = tgt; m_mis = 0;
      end
      chk("rnd_pc", pc, m_pc);
      chk("rnd_mis", {31'b0, misaligned}, {31'b0, m_mis});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_adder_control.md
PC_ADDER_CONTROL -- requirements
Module: pc_adder_control

Interface
REQ-001 Parameter XLEN, default 32, datapath width of all address/immediate ports.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, value loaded into pc on reset.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset; synchronous, active-high.
REQ-005 Port enpc  input  1  1 = load computed next_pc; 0 = sequential pc+4.
REQ-006 Port jal  input  1  unconditional PC-relative jump.
REQ-007 Port jalr  input  1  register-indirect jump.
REQ-008 Port b  input  1  current instruction is a conditional branch.
REQ-009 Port comp  input  1  branch comparison result (1 = condition true).
REQ-010 Port rd1  input  XLEN  register operand used as jalr target.
REQ-011 Port imm_j  input  XLEN  sign-extended jal offset.
REQ-012 Port imm_b  input  XLEN  sign-extended branch offset.
REQ-013 Port pc  output  XLEN  registered program counter.
REQ-014 Port pc_plus4  output  XLEN  combinational pc + 4.
REQ-015 Port next_pc  output  XLEN  combinational value pc will take at next edge when enpc=1.
REQ-016 Port redirect  output  1  combinational; 1 when next_pc differs from sequential path selection (jalr or taken).
REQ-017 Port misaligned  output  1  registered misaligned-target flag (see Configuration).

Function
REQ-018 taken SHALL equal jal OR (comp AND b).
REQ-019 offset SHALL be imm_b when b=1, else imm_j (jal=1 with b=1 uses imm_b).
REQ-020 increment SHALL be offset when taken=1, else constant 4.
REQ-021 sum SHALL be pc + increment, modulo 2^XLEN; carry discarded, wrap-around permitted.
REQ-022 next_pc SHALL be {rd1[XLEN-1:1],1'b0} when jalr=1 (jalr has priority over jal/b), else sum.
REQ-023 redirect SHALL equal jalr OR taken.
REQ-024 On each rising clk with rst=0 and enpc=1, pc SHALL load next_pc.
REQ-025 On each rising clk with rst=0 and enpc=0, pc SHALL load pc + 4 regardless of jal/jalr/b/comp.
REQ-026 pc_plus4, next_pc, redirect SHALL be purely combinational from current pc and inputs, zero-cycle latency; pc update latency exactly one cycle.
REQ-027 Negative offsets SHALL be handled by two's-complement addition (no sign special-casing).

Reset
REQ-028 With rst=1 at a rising edge, pc SHALL become RESET_PC and misaligned SHALL become 0; rst overrides enpc and all control inputs.
REQ-029 Reset asserted mid-sequence SHALL take effect at the next edge; first post-reset edge with rst=0 updates pc per REQ-024/025.

Configuration
REQ-030 Macro PC_MISALIGN_CHECK_EN: when defined, if enpc=1 and redirect=1 and next_pc[1:0]!=0, pc SHALL hold its value and misaligned SHALL be 1 for that cycle (cleared next edge unless condition repeats).
REQ-031 When PC_MISALIGN_CHECK_EN is not defined, misaligned SHALL be constant 0 and pc SHALL load next_pc unconditionally per REQ-024.

Verification
REQ-032 rst=1 one edge, then enpc=0 three edges -> pc 0x0, 0x4, 0x8, 0xC.
REQ-033 pc=0x10, enpc=1, b=1, comp=1, imm_b=0xFFFF_FFF8 -> next_pc=0x08, redirect=1, pc=0x08 after edge; same with comp=0 -> pc=0x14.
REQ-034 pc=0x20, enpc=1, jal=1, imm_j=0x100 -> pc=0x120; same with enpc=0 -> pc=0x24.
REQ-035 pc=0x40, enpc=1, jalr=1, jal=1, rd1=0x0000_1235 -> pc=0x1234 (jalr priority, bit0 cleared).
REQ-036 pc=0xFFFF_FFFC, enpc=1, no jump -> pc=0x0 (wrap); rst=1 together with jal=1 -> pc=RESET_PC.
REQ-037 Macro defined: pc=0x0, enpc=1, jal=1, imm_j=0x2 -> pc stays 0x0, misaligned=1 one cycle; macro undefined -> pc=0x2, misaligned=0.
